// File: rtl/clk_div_bank.sv
// Bank of independent 50%-duty clock dividers with tick strobes,
// shared phase-align sync and runtime divisor updates applied at wrap.
module clk_div_bank #(
   parameter int unsigned SYS_CLK = 100000000,
   parameter int unsigned N_CH    = 2,
   parameter int unsigned CH_W    = 1,
   parameter int unsigned CNT_W   = 23,
   parameter logic [N_CH*CNT_W-1:0] DEF_MAX = {23'd4166665, 23'd263157}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  en,
   input  logic             sync,
   input  logic             wr_en,
   input  logic [CH_W-1:0]  wr_ch,
   input  logic [CNT_W-1:0] wr_max,
   output logic [N_CH-1:0]  clk_out,
   output logic [N_CH-1:0]  tick,
   output logic [N_CH-1:0]  pend
);

   if (N_CH < 1 || N_CH > 16 || (2**CH_W) < N_CH || SYS_CLK == 0) begin : g_bad_cfg
      $error("clk_div_bank: illegal parameter set");
   end

   logic [CNT_W-1:0] cnt_q  [N_CH];
   logic [CNT_W-1:0] cnt_d  [N_CH];
   logic [CNT_W-1:0] max_q  [N_CH];
   logic [CNT_W-1:0] max_d  [N_CH];
   logic [CNT_W-1:0] pmax_q [N_CH];
   logic [CNT_W-1:0] pmax_d [N_CH];
   logic [N_CH-1:0]  clk_q, clk_d;
   logic [N_CH-1:0]  tick_q, tick_d;
   logic [N_CH-1:0]  pend_q, pend_d;

   always_comb begin
      cnt_d  = cnt_q;
      max_d  = max_q;
      pmax_d = pmax_q;
      clk_d  = clk_q;
      tick_d = '0;
      pend_d = pend_q;
      for (int i = 0; i < N_CH; i++) begin
         // sync and wrap share the divisor-apply point, so max only moves when cnt is 0
         if (sync || (en[i] && cnt_q[i] == max_q[i])) begin
            cnt_d[i]  = '0;
            clk_d[i]  = sync ? 1'b0 : ~clk_q[i];
            tick_d[i] = ~sync & ~clk_q[i];
            if (pend_q[i]) begin
               max_d[i]  = pmax_q[i];
               pend_d[i] = 1'b0;
            end
         end else if (en[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
         if (wr_en && wr_ch == CH_W'(i)) begin
            pmax_d[i] = wr_max;
            pend_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i]  <= '0;
            max_q[i]  <= DEF_MAX[i*CNT_W +: CNT_W];
            pmax_q[i] <= '0;
         end
         clk_q  <= '0;
         tick_q <= '0;
         pend_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         max_q  <= max_d;
         pmax_q <= pmax_d;
         clk_q  <= clk_d;
         tick_q <= tick_d;
         pend_q <= pend_d;
      end
   end

   assign clk_out = clk_q;
   assign tick    = tick_q;
   assign pend    = pend_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: steady-state table plus
// hand-built sequences for reset, divisor writes, enable and sync.
module tb_clk_div_bank;

   typedef struct {
      logic       rst_n;
      logic [2:0] en;
      logic       sync;
      logic       wr_en;
      logic [1:0] wr_ch;
      logic [3:0] wr_max;
      logic [2:0] e_clk;
      logic [2:0] e_tick;
      logic [2:0] e_pend;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] en = 3'b111;
   logic       sync = 1'b0;
   logic       wr_en = 1'b0;
   logic [1:0] wr_ch = '0;
   logic [3:0] wr_max = '0;
   logic [2:0] clk_out, tick, pend;

   int total = 0;
   int bad = 0;
   vec_t tbl [41];

   clk_div_bank #(
      .N_CH(3),
      .CH_W(2),
      .CNT_W(4),
      .DEF_MAX({4'd0, 4'd2, 4'd4})
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .sync(sync),
      .wr_en(wr_en),
      .wr_ch(wr_ch),
      .wr_max(wr_max),
      .clk_out(clk_out),
      .tick(tick),
      .pend(pend)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en    = 3'b111;
      sync  = 1'b0;
      wr_en = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_tick(input int ch, input int exp, input string nm);
      int n = 0;
      bit got = 1'b0;
      while (!got && n < 64) begin
         step();
         n++;
         got = tick[ch];
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL %s: got no tick want %0d", nm, exp);
      end else begin
         check(nm, n, exp);
      end
   endtask

   initial begin
      int first [3];
      int second [3];

      for (int k = 0; k <= 40; k++) begin
         tbl[k].rst_n  = (k != 0);
         tbl[k].en     = 3'b111;
         tbl[k].sync   = 1'b0;
         tbl[k].wr_en  = 1'b0;
         tbl[k].wr_ch  = '0;
         tbl[k].wr_max = '0;
         tbl[k].e_clk  = {1'(k % 2), 1'((k / 3) % 2), 1'((k / 5) % 2)};
         tbl[k].e_tick = {1'(k % 2), (k % 6 == 3), (k % 10 == 5)};
         tbl[k].e_pend = '0;
      end

      for (int k = 0; k <= 40; k++) begin
         rst_n  = tbl[k].rst_n;
         en     = tbl[k].en;
         sync   = tbl[k].sync;
         wr_en  = tbl[k].wr_en;
         wr_ch  = tbl[k].wr_ch;
         wr_max = tbl[k].wr_max;
         step();
         check($sformatf("run%0d_clk", k), clk_out, tbl[k].e_clk);
         check($sformatf("run%0d_tick", k), tick, tbl[k].e_tick);
         check($sformatf("run%0d_pend", k), pend, tbl[k].e_pend);
      end

      // reset in the middle of a high half-period, with a write pending
      do_reset();
      repeat (7) step();
      wr_en = 1'b1; wr_ch = 2'd1; wr_max = 4'd5;
      step();
      wr_en = 1'b0;
      check("rmid_pre_clk0", clk_out[0], 1);
      check("rmid_pre_pend", pend, 3'b010);
      rst_n = 1'b0;
      step();
      check("rmid_clk", clk_out, 0);
      check("rmid_tick", tick, 0);
      check("rmid_pend", pend, 0);
      rst_n = 1'b1;
      wait_tick(1, 3, "rmid_first1");
      wait_tick(0, 2, "rmid_first0");

      // divisor change mid half-period
      do_reset();
      step();
      step();
      wr_en = 1'b1; wr_ch = 2'd0; wr_max = 4'd1;
      step();
      wr_en = 1'b0;
      check("wr_pend_set", pend, 3'b001);
      step();
      check("wr_pend_hold", pend, 3'b001);
      step();
      check("wr_pend_clr", pend, 0);
      check("wr_old_tick", tick[0], 1);
      wait_tick(0, 4, "wr_new_per_a");
      wait_tick(0, 4, "wr_new_per_b");
      wr_en = 1'b1; wr_ch = 2'd3; wr_max = 4'd9;
      step();
      wr_en = 1'b0;
      check("oor_pend", pend, 0);
      wait_tick(0, 3, "oor_per0");

      // write landing in the wrap cycle of ch1
      do_reset();
      step();
      step();
      wr_en = 1'b1; wr_ch = 2'd1; wr_max = 4'd7;
      step();
      wr_en = 1'b0;
      check("wwrap_clk1", clk_out[1], 1);
      check("wwrap_tick1", tick[1], 1);
      check("wwrap_pend", pend, 3'b010);
      step();
      step();
      check("wwrap_hold_pend", pend, 3'b010);
      check("wwrap_hold_clk1", clk_out[1], 1);
      step();
      check("wwrap_apply_clk1", clk_out[1], 0);
      check("wwrap_apply_pend", pend, 0);
      wait_tick(1, 8, "wwrap_rise");
      wait_tick(1, 16, "wwrap_per16");

      // freeze ch1 for four cycles
      do_reset();
      repeat (4) step();
      en = 3'b101;
      for (int j = 0; j < 4; j++) begin
         step();
         check($sformatf("frz%0d_clk1", j), clk_out[1], 1);
         check($sformatf("frz%0d_tick1", j), tick[1], 0);
         if (j == 0) check("frz_tick0", tick[0], 1);
      end
      en = 3'b111;
      step();
      check("resume_a_clk1", clk_out[1], 1);
      step();
      check("resume_b_clk1", clk_out[1], 0);
      wait_tick(1, 3, "resume_rise1");

      // sync realigns all channels
      sync = 1'b1;
      step();
      sync = 1'b0;
      check("sync_clk", clk_out, 0);
      check("sync_tick", tick, 0);
      for (int c = 0; c < 3; c++) begin
         first[c] = 0;
         second[c] = 0;
      end
      for (int n = 1; n <= 16; n++) begin
         step();
         for (int c = 0; c < 3; c++) begin
            if (tick[c]) begin
               if (first[c] == 0) first[c] = n;
               else if (second[c] == 0) second[c] = n;
            end
         end
      end
      check("sync_first0", first[0], 5);
      check("sync_first1", first[1], 3);
      check("sync_first2", first[2], 1);
      check("sync_second0", second[0], 15);
      check("sync_second1", second[1], 9);
      check("sync_second2", second[2], 3);

      // sync together with a fresh write on ch0
      do_reset();
      wr_en = 1'b1; wr_ch = 2'd0; wr_max = 4'd3;
      step();
      check("sw_pend_a", pend, 3'b001);
      sync = 1'b1; wr_max = 4'd6;
      step();
      sync = 1'b0; wr_en = 1'b0;
      check("sw_clk", clk_out, 0);
      check("sw_pend_b", pend, 3'b001);
      wait_tick(0, 4, "sw_first0");
      check("sw_pend_c", pend, 0);
      wait_tick(0, 14, "sw_per14");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
